// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit position per clock, with start/ready accept and a one-cycle done pulse.
// Supports SRL, SLL, SRA and ROR. dataout, cout and zero update only on the edge that enters DONE.
module seq_shift_unit #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  dataa,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    mode,
  output logic          ready,
  output logic          done,
  output logic [N-1:0]  dataout,
  output logic          zero,
  output logic          cout
);

  // CW must hold a count of N; KW must hold both shamt and N for comparison.
  localparam int CW = $clog2(N + 1);
  localparam int KW = (SW > CW) ? SW : CW;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sh;
  logic [1:0]    r_mode;
  logic [N-1:0]  r_dataout;
  logic          r_cout;

  logic          w_accept;
  logic          w_last_step;
  logic [KW-1:0] w_shamt_ext;
  logic [CW-1:0] w_k;
  logic [N-1:0]  w_sh_nxt;
  logic          w_out_bit;

  assign w_shamt_ext = KW'(shamt);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last_step = (r_state == S_SHIFT) && (r_cnt == CW'(1));

  // Rotates wrap modulo N; the other modes saturate at N steps.
  always_comb begin
    w_k = '0;
    if (mode == MODE_ROR) begin
      w_k = CW'(w_shamt_ext % KW'(N));
    end else if (w_shamt_ext >= KW'(N)) begin
      w_k = CW'(N);
    end else begin
      w_k = CW'(w_shamt_ext);
    end
  end

  always_comb begin
    w_sh_nxt  = r_sh;
    w_out_bit = 1'b0;
    case (r_mode)
      MODE_SRL: begin
        w_sh_nxt  = {1'b0, r_sh[N-1:1]};
        w_out_bit = r_sh[0];
      end
      MODE_SLL: begin
        w_sh_nxt  = {r_sh[N-2:0], 1'b0};
        w_out_bit = r_sh[N-1];
      end
      MODE_SRA: begin
        w_sh_nxt  = {r_sh[N-1], r_sh[N-1:1]};
        w_out_bit = r_sh[0];
      end
      MODE_ROR: begin
        w_sh_nxt  = {r_sh[0], r_sh[N-1:1]};
        w_out_bit = r_sh[0];
      end
      default: begin
        w_sh_nxt  = r_sh;
        w_out_bit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_nxt = (w_k == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Result registers move only when DONE is entered, so an aborted run leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_mode    <= MODE_SRL;
      r_cnt     <= '0;
      r_dataout <= '0;
      r_cout    <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= dataa;
      r_mode <= mode;
      r_cnt  <= w_k;
      if (w_k == '0) begin
        r_dataout <= dataa;
        r_cout    <= 1'b0;
      end
    end else if (r_state == S_SHIFT) begin
      r_sh  <= w_sh_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last_step) begin
        r_dataout <= w_sh_nxt;
        r_cout    <= w_out_bit;
      end
    end
  end

  assign dataout = r_dataout;
  assign cout    = r_cout;
  assign zero    = (r_dataout == '0);

endmodule
